// File: rtl/calc1_pkg.sv
// Shared constants and state encoding for the calc1 port responder.
package calc1_pkg;

    localparam logic [0:3] CMD_NONE = 4'd0;
    localparam logic [0:3] CMD_ADD  = 4'd1;
    localparam logic [0:3] CMD_SUB  = 4'd2;
    localparam logic [0:3] CMD_SHL  = 4'd5;
    localparam logic [0:3] CMD_SHR  = 4'd6;

    localparam logic [0:1] RESP_NONE = 2'd0;
    localparam logic [0:1] RESP_OK   = 2'd1;
    localparam logic [0:1] RESP_ERR  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OPND2,
        ST_EXEC,
        ST_RESP
    } state_e;

endpackage

// File: rtl/calc1_alu.sv
// Combinational calc1 ALU: add/sub with overflow detection, logical shifts,
// and mapping of unknown command codes to an error response.
module calc1_alu
    import calc1_pkg::*;
(
    input  logic [0:3]  cmd,
    input  logic [0:31] op1,
    input  logic [0:31] op2,
    output logic [0:1]  resp,
    output logic [0:31] data
);

    logic [32:0] sum;
    logic [4:0]  shamt;

    assign sum   = {1'b0, op1} + {1'b0, op2};
    // Only the five least significant bits of op2 select the shift distance.
    assign shamt = op2[27:31];

    always_comb begin
        resp = RESP_ERR;
        data = '0;
        case (cmd)
            CMD_ADD: begin
                if (!sum[32]) begin
                    resp = RESP_OK;
                    data = sum[31:0];
                end
            end
            CMD_SUB: begin
                if (op2 <= op1) begin
                    resp = RESP_OK;
                    data = op1 - op2;
                end
            end
            CMD_SHL: begin
                resp = RESP_OK;
                data = op1 << shamt;
            end
            CMD_SHR: begin
                resp = RESP_OK;
                data = op1 >> shamt;
            end
            default: begin
                resp = RESP_ERR;
                data = '0;
            end
        endcase
    end

endmodule

// File: rtl/calc1_port_responder.sv
// DUT-side end of one calc1 port: two-cycle request capture, fixed-latency
// execute, one-cycle registered response.
module calc1_port_responder
    import calc1_pkg::*;
#(
    parameter int unsigned LATENCY = 3
) (
    input  logic        c_clk,
    input  logic        reset_n,
    input  logic [0:3]  req_cmd_in,
    input  logic [0:31] req_data_in,
    output logic [0:1]  out_resp,
    output logic [0:31] out_data,
    output logic        busy
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [0:3]  cmd_q,   cmd_d;
    logic [0:31] op1_q,   op1_d;
    logic [0:31] op2_q,   op2_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [0:1]  resp_q,  resp_d;
    logic [0:31] data_q,  data_d;
    logic        busy_q,  busy_d;

    logic [0:1]  alu_resp;
    logic [0:31] alu_data;

    calc1_alu u_alu (
        .cmd  (cmd_q),
        .op1  (op1_q),
        .op2  (op2_q),
        .resp (alu_resp),
        .data (alu_data)
    );

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_NONE;
            op1_q   <= '0;
            op2_q   <= '0;
            cnt_q   <= '0;
            resp_q  <= RESP_NONE;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        // Response registers self-clear so a result is visible for one cycle only.
        resp_d  = RESP_NONE;
        data_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_cmd_in != CMD_NONE) begin
                    cmd_d   = req_cmd_in;
                    op1_d   = req_data_in;
                    busy_d  = 1'b1;
                    state_d = ST_OPND2;
                end
            end
            ST_OPND2: begin
                op2_d   = req_data_in;
                cnt_d   = CNT_LOAD;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (cnt_q == 4'd0) begin
                    resp_d  = alu_resp;
                    data_d  = alu_data;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign out_resp = resp_q;
    assign out_data = data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_calc1_port_responder.sv
// Self-checking bench for calc1_port_responder: directed table, randomized
// transactions against a behavioural model, and reset-abort sequences.
module tb_calc1_port_responder;

    localparam int L = 3;

    logic        c_clk = 1'b0;
    logic        reset_n;
    logic [0:3]  req_cmd_in;
    logic [0:31] req_data_in;
    logic [0:1]  out_resp;
    logic [0:31] out_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    calc1_port_responder #(.LATENCY(L)) dut (
        .c_clk       (c_clk),
        .reset_n     (reset_n),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .busy        (busy)
    );

    always #5 c_clk = ~c_clk;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  resp;
        logic [31:0] data;
        bit          junk;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    // Behavioural model straight from the arithmetic rules of the protocol.
    function automatic void ref_calc(input int unsigned cmd, input longint unsigned a,
                                     input longint unsigned b, output logic [1:0] resp,
                                     output logic [31:0] data);
        longint unsigned r;
        resp = 2'd2;
        data = 32'd0;
        case (cmd)
            1: begin
                r = a + b;
                if (r <= 64'hFFFF_FFFF) begin resp = 2'd1; data = r[31:0]; end
            end
            2: begin
                if (b <= a) begin r = a - b; resp = 2'd1; data = r[31:0]; end
            end
            5: begin r = (a << (b % 32)) & 64'hFFFF_FFFF; resp = 2'd1; data = r[31:0]; end
            6: begin r = a >> (b % 32); resp = 2'd1; data = r[31:0]; end
            default: ;
        endcase
    endfunction

    // Entered at a negedge with the DUT idle; returns at the negedge after RESP,
    // where a following command may be driven immediately.
    task automatic do_txn(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] er, input logic [31:0] ed, input bit junk,
                          input string tag);
        req_cmd_in  = cmd;
        req_data_in = a;
        @(negedge c_clk);
        chk({tag, " busy_opnd2"}, 32'(busy), 32'd1);
        chk({tag, " resp_opnd2"}, 32'(out_resp), 32'd0);
        req_data_in = b;
        req_cmd_in  = junk ? 4'($urandom_range(1, 15)) : 4'd0;
        for (int j = 2; j <= L + 1; j++) begin
            @(negedge c_clk);
            chk($sformatf("%s resp_pre%0d", tag, j), 32'(out_resp), 32'd0);
            if (junk) begin
                req_cmd_in  = 4'd1;
                req_data_in = $urandom;
            end else begin
                req_cmd_in = 4'd0;
            end
        end
        @(negedge c_clk);
        chk({tag, " resp"}, 32'(out_resp), 32'(er));
        chk({tag, " data"}, out_data, ed);
        chk({tag, " busy_resp"}, 32'(busy), 32'd1);
        req_cmd_in = junk ? 4'd2 : 4'd0;
        @(negedge c_clk);
        chk({tag, " resp_post"}, 32'(out_resp), 32'd0);
        chk({tag, " data_post"}, out_data, 32'd0);
        chk({tag, " busy_post"}, 32'(busy), 32'd0);
        req_cmd_in = 4'd0;
        $display("txn %s cmd=%0d a=0x%08h b=0x%08h resp=%0d data=0x%08h", tag, cmd, a, b, er, ed);
    endtask

    task automatic idle_watch(input int n, input string tag);
        req_cmd_in = 4'd0;
        for (int j = 0; j < n; j++) begin
            @(negedge c_clk);
            chk($sformatf("%s idle_resp%0d", tag, j), 32'(out_resp), 32'd0);
        end
    endtask

    initial begin
        logic [3:0]  rc;
        logic [31:0] ra, rb, rd;
        logic [1:0]  rr;

        tbl[0] = '{4'd1, 32'h0000_0001, 32'h0000_0001, 2'd1, 32'h0000_0002, 1'b0};
        tbl[1] = '{4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000, 1'b0};
        tbl[2] = '{4'd1, 32'h7FFF_FFFF, 32'h8000_0000, 2'd1, 32'hFFFF_FFFF, 1'b0};
        tbl[3] = '{4'd2, 32'h0000_0005, 32'h0000_0007, 2'd2, 32'h0000_0000, 1'b0};
        tbl[4] = '{4'd2, 32'h0000_0007, 32'h0000_0007, 2'd1, 32'h0000_0000, 1'b0};
        tbl[5] = '{4'd5, 32'h0000_0001, 32'h0000_001F, 2'd1, 32'h8000_0000, 1'b0};
        tbl[6] = '{4'd6, 32'h8000_0000, 32'h0000_001F, 2'd1, 32'h0000_0001, 1'b0};
        tbl[7] = '{4'd5, 32'h0000_0001, 32'h0000_0020, 2'd1, 32'h0000_0001, 1'b0};
        tbl[8] = '{4'd3, 32'h0000_1234, 32'h0000_5678, 2'd2, 32'h0000_0000, 1'b0};
        tbl[9] = '{4'd1, 32'h0000_0064, 32'h0000_0017, 2'd1, 32'h0000_007B, 1'b1};

        reset_n     = 1'b0;
        req_cmd_in  = 4'd0;
        req_data_in = 32'd0;
        repeat (3) @(negedge c_clk);
        chk("reset resp", 32'(out_resp), 32'd0);
        chk("reset data", out_data, 32'd0);
        chk("reset busy", 32'(busy), 32'd0);

        // Release reset with the first command already on the bus.
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++)
            do_txn(tbl[i].cmd, tbl[i].a, tbl[i].b, tbl[i].resp, tbl[i].data, tbl[i].junk,
                   $sformatf("vec%0d", i));
        idle_watch(L + 4, "after_junk");

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 4))
                0: rc = 4'd1;
                1: rc = 4'd2;
                2: rc = 4'd5;
                3: rc = 4'd6;
                default: rc = ($urandom_range(0, 1) == 0) ? 4'd3 : 4'($urandom_range(7, 15));
            endcase
            ra = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            case (i % 4)
                0: rb = ~ra;
                1: rb = ~ra + 32'd1;
                2: rb = 32'($urandom_range(0, 40));
                default: rb = $urandom;
            endcase
            ref_calc(rc, ra, rb, rr, rd);
            do_txn(rc, ra, rb, rr, rd, 1'b0, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1) idle_watch(1, $sformatf("gap%0d", i));
        end

        // Abort during EXEC: busy must drop asynchronously and nothing follows.
        req_cmd_in  = 4'd1;
        req_data_in = 32'd10;
        @(negedge c_clk);
        req_cmd_in  = 4'd0;
        req_data_in = 32'd20;
        @(negedge c_clk);
        chk("abort_exec busy_before", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_exec busy", 32'(busy), 32'd0);
        chk("abort_exec resp", 32'(out_resp), 32'd0);
        chk("abort_exec data", out_data, 32'd0);
        @(negedge c_clk);
        reset_n = 1'b1;
        idle_watch(L + 4, "abort_exec");
        do_txn(4'd1, 32'd2, 32'd3, 2'd1, 32'd5, 1'b0, "post_abort");

        // Abort during RESP: visible response must clear without waiting for a clock.
        req_cmd_in  = 4'd1;
        req_data_in = 32'd40;
        @(negedge c_clk);
        req_cmd_in  = 4'd0;
        req_data_in = 32'd2;
        repeat (L + 1) @(negedge c_clk);
        chk("abort_resp resp_before", 32'(out_resp), 32'd1);
        chk("abort_resp data_before", out_data, 32'd42);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_resp resp", 32'(out_resp), 32'd0);
        chk("abort_resp data", out_data, 32'd0);
        chk("abort_resp busy", 32'(busy), 32'd0);
        @(negedge c_clk);
        reset_n = 1'b1;
        idle_watch(L + 4, "abort_resp");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calc1_port_responder.md
# calc1_port_responder

Single-port responder for the calc1 request/response protocol. It accepts a two-cycle request on a `req_cmd_in`/`req_data_in` pair, executes add, subtract, shift-left or shift-right after a fixed pipeline latency, and returns a one-cycle response code plus result on `out_resp`/`out_data`. It is the DUT-side end of the calc1 port that our directed benches drive. Four instances make up a full calc1 core.

## Interface
- `LATENCY`, default 3: execute cycles between second-operand capture and response (legal 1..15).
- `c_clk` input 1: sole clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req_cmd_in` input [0:3]: command. 0 = none, 1 = add, 2 = sub, 5 = shift left, 6 = shift right. All other codes are invalid.
- `req_data_in` input [0:31]: operand bus. Bit 31 is the LSB.
- `out_resp` output [0:1]: 0 = no response, 1 = success, 2 = overflow/underflow/invalid command, 3 = never driven.
- `out_data` output [0:31]: result. Valid only in the cycle where `out_resp` = 1; 0 otherwise.
- `busy` output 1: high from the operand-1 capture cycle through the response cycle inclusive.

## Operation
- States: IDLE, OPND2, EXEC, RESP.
- IDLE: when `req_cmd_in` != 0, latch the command and latch `req_data_in` as op1, then go to OPND2. When `req_cmd_in` = 0, stay in IDLE.
- OPND2: latch `req_data_in` as op2 unconditionally, load the latency counter with `LATENCY`-1, then go to EXEC. `req_cmd_in` is ignored in this state.
- EXEC: decrement the counter each cycle. When the counter reaches 0, register the ALU result and go to RESP.
- RESP: drive `out_resp`/`out_data` for exactly one cycle, then go to IDLE.
- Any `req_cmd_in` that arrives while not in IDLE is dropped with no response. The bench must not rely on queueing.
- Add: compute op1+op2 as a 33-bit sum. If the carry-out is 1, respond with 2 and data 0. Otherwise respond with 1 and the low 32 bits.
- Sub: if op2 > op1 (unsigned), respond with 2 and data 0 (underflow). Otherwise respond with 1 and op1-op2.
- Shift left / shift right: shift op1 logically by op2[27:31] (5 bits). op2[0:26] is ignored. Always respond with 1.
- Invalid command code: respond with 2 and data 0 after the normal latency.

## Timing
- Cycle n: command and op1 are sampled.
- Cycle n+1: op2 is sampled.
- Cycles n+2 .. n+1+LATENCY: EXEC.
- Cycle n+2+LATENCY: `out_resp` is non-zero for one cycle.
- Total command-to-response latency is LATENCY+2 cycles.
- Earliest next accepted command is the cycle after RESP, i.e. n+3+LATENCY. Minimum spacing between accepted commands is LATENCY+3 cycles.
- All outputs are registered. Reset values: `out_resp` = 0, `out_data` = 0, `busy` = 0, state = IDLE, counter = 0, latched operands = 0.
- Asserting reset in any state aborts the operation immediately. No response is ever produced for the aborted request.
- After reset deassertion, a command present in the first active clock edge is accepted.

## Structure
- `calc1_pkg` holds:
  - command code constants (CMD_NONE, CMD_ADD, CMD_SUB, CMD_SHL, CMD_SHR);
  - response code constants (RESP_NONE, RESP_OK, RESP_ERR);
  - the state enum.
- Sub-module `calc1_alu`: purely combinational. Inputs are cmd, op1 and op2; outputs are resp [0:1] and data [0:31]. Add/sub overflow detection and invalid-code mapping live here.
- The top level contains only the FSM, the counter, and the operand and output registers.

## Test plan
- Add 1 + 1 with LATENCY=3: `out_resp` = 1 and `out_data` = 2 exactly 5 cycles after the command cycle. `out_resp` = 0 in the cycle before and the cycle after.
- Add 0xFFFFFFFF + 1: `out_resp` = 2, `out_data` = 0. Add 0x7FFFFFFF + 0x80000000: `out_resp` = 1, `out_data` = 0xFFFFFFFF.
- Sub 5 − 7: `out_resp` = 2, `out_data` = 0. Sub 7 − 7: `out_resp` = 1, `out_data` = 0.
- Shift left 1 by 31: 0x80000000. Shift right 0x80000000 by 31: 1. Shift left 1 by op2 = 0x00000020 (low bits 0): 1.
- Command 3 with any operands: `out_resp` = 2 after LATENCY+2 cycles. A second add issued while `busy` = 1 produces no second response.
- Pull `reset_n` low during EXEC: outputs go to 0 asynchronously and no response follows. A new add 2 + 3 issued after release returns `out_resp` = 1, `out_data` = 5.
